lc3_mem_responder: RTL
======================

// Module: lc3_mem_responder
// PURPOSE
// - Memory-side responder for the LC-3 datapath's MAR/MDR bus requests.
// - Decodes each read/write request, services it from external async SRAM with fixed wait
//   states, or from the memory-mapped I/O register at IO_ADDR.
// - Returns read data plus a one-cycle ready pulse R, which the control FSM uses to leave
//   its memory wait states.
// PARAMETERS
// - WAIT_CYCLES  2        SRAM access cycles per transaction; must be >= 1
// - IO_ADDR      16'hFFFF address of the I/O port (read = Switches, write = HEX_Data)
// - SRAM_AW      20       SRAM address width; upper bits are zero-filled
// PORTS
// - Clk           in   1        system clock; all logic on posedge
// - Reset         in   1        synchronous, active-high
// - MEM_RD        in   1        read request (level, held by CPU FSM)
// - MEM_WR        in   1        write request (level); wins if MEM_RD also high
// - ADDR          in   16       request address (MAR)
// - Data_from_CPU in   16       write data (MDR)
// - Data_to_CPU   out  16       read data; feeds the MDR input mux
// - R             out  1        ready pulse, exactly 1 cycle per transaction
// - Switches      in   16       I/O read source
// - HEX_Data      out  16       I/O write register
// - SRAM_ADDR     out  SRAM_AW  SRAM address
// - SRAM_CE_N     out  1        SRAM chip enable, active-low
// - SRAM_OE_N     out  1        SRAM output enable, active-low
// - SRAM_WE_N     out  1        SRAM write enable, active-low
// - SRAM_DQ_out   out  16       write data driven to SRAM
// - SRAM_DQ_oe    out  1        1 = drive SRAM_DQ_out onto the pad
// - SRAM_DQ_in    in   16       read data from SRAM
// BEHAVIOUR
// - Reset values:
//   - State = IDLE; R = 0; Data_to_CPU = 0; HEX_Data = 0; SRAM_ADDR = 0.
//   - SRAM_CE_N, SRAM_OE_N and SRAM_WE_N = 1; SRAM_DQ_oe = 0; SRAM_DQ_out = 0.
// - Reset mid-transaction aborts it immediately: no R pulse, strobes released next edge.
// - FSM states: IDLE, ACCESS, DONE, RELEASE.
// - IDLE:
//   - At each edge with MEM_RD | MEM_WR, latch ADDR, Data_from_CPU and the direction
//     (write if MEM_WR).
//   - Address == IO_ADDR -> DONE: a read captures Switches into Data_to_CPU at that edge;
//     a write loads HEX_Data at that edge.
//   - Otherwise -> ACCESS with the wait counter = WAIT_CYCLES-1.
// - ACCESS:
//   - SRAM_ADDR = zero-extended latched address; SRAM_CE_N = 0.
//   - Read: SRAM_OE_N = 0, SRAM_WE_N = 1, SRAM_DQ_oe = 0.
//   - Write: SRAM_WE_N = 0, SRAM_OE_N = 1, SRAM_DQ_oe = 1, SRAM_DQ_out = latched data.
//   - Counter decrements each cycle. When it is 0, a read captures SRAM_DQ_in into
//     Data_to_CPU, then the FSM moves to DONE.
// - DONE:
//   - R = 1 for this cycle only; all strobes deasserted; SRAM_DQ_oe = 0.
//   - Next state: IDLE if MEM_RD = MEM_WR = 0, else RELEASE.
// - RELEASE:
//   - R = 0; stay until MEM_RD = MEM_WR = 0, then IDLE.
//   - Guarantees one access per request level, even though the CPU holds MEM_RD across
//     several states.
// - Latency, request first sampled at edge t:
//   - SRAM: R high in cycle t+WAIT_CYCLES+1.
//   - I/O: R high in cycle t+1.
// - Request dropped during ACCESS: the access still completes and R still pulses.
// - Data_to_CPU holds the last completed read value; writes never change it.
// - ADDR and Data_from_CPU changing after the latch edge have no effect on the current
//   transaction.
// - WE_N and OE_N are never low in the same cycle. SRAM_DQ_oe = 1 only while
//   SRAM_WE_N = 0.
// - Counter width = $clog2(WAIT_CYCLES+1); no wrap is possible.
// STRUCTURE
// - Package lc3_mem_pkg: mem_state_t enum {IDLE, ACCESS, DONE, RELEASE},
//   LC3_IO_ADDR = 16'hFFFF, LC3_WORD_W = 16.
// - Sub-module mem_wait_counter (load, dec, zero flag), parameterized by WAIT_CYCLES.
// - Everything else: one FSM always_ff plus one always_comb output decode.
// TESTING
// - SRAM read: after reset, preload DQ_in = 16'h1234, MEM_RD = 1, ADDR = 16'h0040, W = 2
//   -> CE_N/OE_N low for 2 cycles; R pulses in cycle 3; Data_to_CPU = 16'h1234;
//   SRAM_ADDR = 20'h00040.
// - SRAM write: MEM_WR = 1, ADDR = 16'h0100, Data = 16'hBEEF -> WE_N low and DQ_oe = 1
//   for 2 cycles with DQ_out = 16'hBEEF; R pulses once; Data_to_CPU unchanged.
// - I/O: Switches = 16'h00A5, MEM_RD at 16'hFFFF -> R in the next cycle,
//   Data_to_CPU = 16'h00A5, SRAM strobes stay high. Write 16'h0042 to 16'hFFFF
//   -> HEX_Data = 16'h0042.
// - Held request: MEM_RD held high for 10 cycles -> exactly one R pulse and one SRAM
//   access; a new access starts only after MEM_RD drops and rises again.
// - Simultaneous MEM_RD = MEM_WR = 1 -> write performed. MEM_RD dropped in the middle of
//   ACCESS -> R still pulses, FSM returns to IDLE.
// - Reset asserted in the first ACCESS cycle -> next cycle all strobes = 1, R = 0,
//   HEX_Data = 0, Data_to_CPU = 0; no R pulse ever appears.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// ============================================================================
// lc3_mem_pkg : shared types and constants for the LC-3 memory responder
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package lc3_mem_pkg;

  localparam int          LC3_WORD_W  = 16;
  localparam logic [15:0] LC3_IO_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wait_counter.sv
// ============================================================================
// mem_wait_counter : SRAM wait-state down counter (load, decrement, zero flag)
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module mem_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  localparam int            CW         = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] c_load_val = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] c_one      = CW'(1);

  logic [CW-1:0] r_cnt;

  // Decrement saturates at zero so a stray dec can never wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_one;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lc3_mem_responder.sv
// ============================================================================
// lc3_mem_responder : services LC-3 MAR/MDR requests from async SRAM or I/O port
// Rev 1.0           : initial release
// ============================================================================
`default_nettype none

module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = LC3_IO_ADDR,
  parameter int          SRAM_AW     = 20
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MEM_RD,
  input  logic                  MEM_WR,
  input  logic [LC3_WORD_W-1:0] ADDR,
  input  logic [LC3_WORD_W-1:0] Data_from_CPU,
  output logic [LC3_WORD_W-1:0] Data_to_CPU,
  output logic                  R,
  input  logic [LC3_WORD_W-1:0] Switches,
  output logic [LC3_WORD_W-1:0] HEX_Data,
  output logic [SRAM_AW-1:0]    SRAM_ADDR,
  output logic                  SRAM_CE_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N,
  output logic [LC3_WORD_W-1:0] SRAM_DQ_out,
  output logic                  SRAM_DQ_oe,
  input  logic [LC3_WORD_W-1:0] SRAM_DQ_in
);

  mem_state_t            r_state;
  logic [LC3_WORD_W-1:0] r_addr;
  logic [LC3_WORD_W-1:0] r_wdata;
  logic                  r_is_wr;
  logic [LC3_WORD_W-1:0] r_rdata;
  logic [LC3_WORD_W-1:0] r_hex;

  logic w_req;
  logic w_is_io;
  logic w_cnt_load;
  logic w_cnt_dec;
  logic w_cnt_zero;

  assign w_req      = MEM_RD | MEM_WR;
  assign w_is_io    = (ADDR == IO_ADDR);
  assign w_cnt_load = (r_state == IDLE) && w_req && !w_is_io;
  assign w_cnt_dec  = (r_state == ACCESS) && !w_cnt_zero;

  mem_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk    (Clk),
    .rst    (Reset),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_rdata <= '0;
      r_hex   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= ADDR;
            r_wdata <= Data_from_CPU;
            r_is_wr <= MEM_WR;
            // I/O completes at the request edge itself, no wait states
            if (w_is_io) begin
              if (MEM_WR) r_hex   <= Data_from_CPU;
              else        r_rdata <= Switches;
              r_state <= DONE;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (w_cnt_zero) begin
            if (!r_is_wr) r_rdata <= SRAM_DQ_in;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= w_req ? RELEASE : IDLE;
        end
        RELEASE: begin
          // Hold here until the CPU drops its request level
          if (!w_req) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    R           = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_CE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_oe  = 1'b0;
    SRAM_DQ_out = '0;
    case (r_state)
      ACCESS: begin
        SRAM_ADDR = SRAM_AW'(r_addr);
        SRAM_CE_N = 1'b0;
        if (r_is_wr) begin
          SRAM_WE_N   = 1'b0;
          SRAM_DQ_oe  = 1'b1;
          SRAM_DQ_out = r_wdata;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      DONE:    R = 1'b1;
      default: ;
    endcase
  end

  assign Data_to_CPU = r_rdata;
  assign HEX_Data    = r_hex;

endmodule

`default_nettype wire
